// File: rtl/sdc_pkg.sv
// sdc_pkg: shared constants, state encoding and the CRC7 step used by the SD command path.
package sdc_pkg;
    localparam int FRAME_BITS   = 48;
    localparam int CRC_BITS     = 7;
    localparam int PAYLOAD_BITS = 40;
    localparam logic [CRC_BITS-1:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {IDLE, CRC, LOAD, SHIFT, GAP} state_t;

    function automatic logic [CRC_BITS-1:0] crc7_next(input logic [CRC_BITS-1:0] c, input logic b);
        return {c[CRC_BITS-2:0], 1'b0} ^ ({CRC_BITS{c[CRC_BITS-1] ^ b}} & CRC7_POLY);
    endfunction
endpackage

// File: rtl/sdc_crc7_serial.sv
// sdc_crc7_serial: bit-serial CRC7 (x^7+x^3+1, init 0), one bit per enabled cycle.
module sdc_crc7_serial
    import sdc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                en,
    input  logic                din,
    output logic [CRC_BITS-1:0] crc
);
    always_ff @(posedge clk)
        if (reset || clr) crc <= '0;
        else if (en) crc <= crc7_next(crc, din);
endmodule

// File: rtl/sdc_cmd_sequencer.sv
// sdc_cmd_sequencer: builds a 48-bit SD command frame with CRC7, loads and shifts it out,
// then holds the CMD line idle for GAP_CYCLES before accepting the next command.
module sdc_cmd_sequencer
    import sdc_pkg::*;
#(
    parameter int GAP_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [5:0]            cmd_index,
    input  logic [31:0]           cmd_arg,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] full_cmd,
    output logic                  load_cmd,
    output logic                  shift_cmd,
    output logic                  cmd_oe
);
    state_t                    state;
    logic [5:0]                idx;
    logic [31:0]               arg;
    logic [5:0]                bit_cnt;
    logic [7:0]                gap_cnt;
    logic [CRC_BITS-1:0]       crc;
    logic [PAYLOAD_BITS-1:0]   payload;
    logic [5:0]                bit_idx;
    logic                      accept;

    assign payload = {2'b01, idx, arg};
    assign bit_idx = 6'(PAYLOAD_BITS - 1) - bit_cnt;
    assign accept  = (state == IDLE) && start;

    sdc_crc7_serial u_crc (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (state == CRC),
        .din   (payload[bit_idx]),
        .crc   (crc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            arg       <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            full_cmd  <= '0;
            load_cmd  <= 1'b0;
            shift_cmd <= 1'b0;
            cmd_oe    <= 1'b0;
        end else begin
            load_cmd <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    idx     <= cmd_index;
                    arg     <= cmd_arg;
                    bit_cnt <= '0;
                    busy    <= 1'b1;
                    state   <= CRC;
                end
                CRC: begin
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt == 6'(PAYLOAD_BITS - 1)) begin
                        // the last payload bit is folded in here since the CRC register lags by one edge
                        full_cmd <= {payload, crc7_next(crc, payload[0]), 1'b1};
                        load_cmd <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    shift_cmd <= 1'b1;
                    cmd_oe    <= 1'b1;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt == 6'(FRAME_BITS - 1)) begin
                        shift_cmd <= 1'b0;
                        cmd_oe    <= 1'b0;
                        bit_cnt   <= '0;
                        gap_cnt   <= '0;
                        done      <= (GAP_CYCLES == 1);
                        state     <= GAP;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                    if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= (gap_cnt == 8'(GAP_CYCLES - 2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdc_cmd_sequencer.sv
// tb_sdc_cmd_sequencer: random and directed commands checked against a frame/timing model.
module tb_sdc_cmd_sequencer;
    localparam int G = 8;

    logic        clk = 1'b0;
    logic        reset, start, start1;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        busy, done, load_cmd, shift_cmd, cmd_oe;
    logic [47:0] full_cmd;
    logic        busy1, done1, load1, shift1, oe1;
    logic [47:0] full1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdc_cmd_sequencer #(.GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .busy(busy), .done(done), .full_cmd(full_cmd), .load_cmd(load_cmd),
        .shift_cmd(shift_cmd), .cmd_oe(cmd_oe)
    );

    sdc_cmd_sequencer #(.GAP_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .busy(busy1), .done(done1), .full_cmd(full1), .load_cmd(load1),
        .shift_cmd(shift1), .cmd_oe(oe1)
    );

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SD frame: start 0, transmit 1, index, argument, CRC7 over those 40 bits, end 1
    function automatic logic [47:0] model_frame(input logic [5:0] i, input logic [31:0] a);
        logic [39:0] p = {2'b01, i, a};
        logic [6:0]  c = '0;
        for (int b = 39; b >= 0; b--) begin
            logic fb = c[6] ^ p[b];
            c = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return {p, c, 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [5:0] i, input logic [31:0] a, input logic hold);
        logic [47:0] exp = model_frame(i, a);
        logic [47:0] sr = '1;
        logic [47:0] got_full = '0;
        int nbusy = 0, ndone = 0, done_at = 0, load_at = 0, both = 0;
        int oe_len = 0, oe_runs = 0, oe_last = 0, bad_bits = 0, cyc = 1;
        logic prev_oe = 1'b0;
        cmd_index = i;
        cmd_arg   = a;
        start     = 1'b1;
        tick();
        start = hold;
        while (busy && cyc < 300) begin
            nbusy++;
            if (load_cmd) begin load_at = cyc; got_full = full_cmd; end
            if (load_cmd && shift_cmd) both++;
            if (done) begin ndone++; done_at = cyc; end
            if (cmd_oe) begin
                oe_len++;
                if (!prev_oe) oe_runs++;
                oe_last = cyc;
                if (oe_len <= 48 && sr[47] !== exp[48-oe_len]) bad_bits++;
            end
            prev_oe = cmd_oe;
            if (load_cmd) sr = full_cmd;
            else if (shift_cmd) sr = {sr[46:0], 1'b1};
            tick();
            cyc++;
        end
        chk("timeout", 48'(cyc >= 300), 48'd0);
        chk("busy_len", 48'(nbusy), 48'(40 + 1 + 48 + G));
        chk("load_at", 48'(load_at), 48'd41);
        chk("full_cmd", got_full, exp);
        chk("done_cnt", 48'(ndone), 48'd1);
        chk("done_at", 48'(done_at), 48'(nbusy));
        chk("oe_len", 48'(oe_len), 48'd48);
        chk("oe_runs", 48'(oe_runs), 48'd1);
        chk("gap_len", 48'(done_at - oe_last), 48'(G));
        chk("load_shift_overlap", 48'(both), 48'd0);
        chk("line_bits_bad", 48'(bad_bits), 48'd0);
        chk("line_idle_high", sr, '1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start1 = 1'b0; cmd_index = '0; cmd_arg = '0;
        repeat (3) tick();
        chk("rst_outs", {43'd0, busy, done, load_cmd, shift_cmd, cmd_oe}, 48'd0);
        chk("rst_full", full_cmd, 48'd0);
        reset = 1'b0;
        tick();

        chk("model_cmd0", model_frame(6'd0, 32'h0), 48'h400000000095);
        chk("model_cmd17", model_frame(6'd17, 32'h0), 48'h510000000055);
        chk("model_cmd8", model_frame(6'd8, 32'h1AA), 48'h48000001AA87);
        run_cmd(6'd0, 32'h0, 1'b0);
        run_cmd(6'd17, 32'h0, 1'b0);
        run_cmd(6'd8, 32'h1AA, 1'b0);

        // start held through a command: exactly one idle cycle, then the next is accepted
        run_cmd(6'd55, 32'hDEADBEEF, 1'b1);
        chk("idle_gap_busy", 48'(busy), 48'd0);
        run_cmd(6'd41, 32'h40FF8000, 1'b0);

        // reset in SHIFT cycle 20 abandons the frame
        cmd_index = 6'd0; cmd_arg = '0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (41 + 19) tick();
        chk("pre_rst_oe", 48'(cmd_oe), 48'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_outs", {43'd0, busy, done, load_cmd, shift_cmd, cmd_oe}, 48'd0);
        chk("mid_rst_full", full_cmd, 48'd0);
        reset = 1'b0;
        begin
            int d = 0;
            repeat (60) begin tick(); if (done || busy) d++; end
            chk("no_done_after_rst", 48'(d), 48'd0);
        end
        run_cmd(6'd0, 32'h0, 1'b0);

        for (int n = 0; n < 300; n++)
            run_cmd(6'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)));

        // GAP_CYCLES=1 build: 90 busy cycles, done in the single gap cycle
        begin
            int nb = 0, da = 0, ol = 0, c = 1;
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            while (busy1 && c < 300) begin
                nb++;
                if (done1) da = c;
                if (oe1) ol = c;
                tick();
                c++;
            end
            chk("g1_busy_len", 48'(nb), 48'd90);
            chk("g1_done_at", 48'(da), 48'd90);
            chk("g1_done_after_oe", 48'(da - ol), 48'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
